// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (CPU controller, debug/loader) in front of the single-port unified memory.
// Define MEM_ARB_DBG_PRIORITY_EN to make the debug port win every tie instead of round robin.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_t              state;
    state_t              next_state;
    logic                grant;
    logic                grant_dbg;
    logic                tie_dbg;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [3:0]          cnt;

    // On a tie the port that did not own the last grant wins, unless debug priority is built in.
`ifdef MEM_ARB_DBG_PRIORITY_EN
    assign tie_dbg = 1'b1;
`else
    assign tie_dbg = ~owner;
`endif

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_dbg  = 1'b0;
        mem_en     = 1'b0;
        cpu_ack    = 1'b0;
        dbg_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    grant      = 1'b1;
                    grant_dbg  = (cpu_req && dbg_req) ? tie_dbg : dbg_req;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                mem_en     = 1'b1;
                next_state = lat_we ? ACK : WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) next_state = ACK;
            end
            ACK: begin
                cpu_ack    = ~owner;
                dbg_ack    = owner;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign mem_we    = lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    // The counter reaches zero in the cycle mem_rdata becomes valid, which is when it is captured.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= 4'd0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            state <= next_state;
            if (grant) begin
                owner     <= grant_dbg;
                lat_we    <= grant_dbg ? dbg_we    : cpu_we;
                lat_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
                lat_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            end
            if (state == ACCESS) begin
                cnt <= LAT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == WAIT && cnt == 4'd0) begin
                if (owner) dbg_rdata <= mem_rdata;
                else       cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3 sharing inputs.
// A scoreboard checks every memory strobe and acknowledge of the MEM_LAT=1 instance.
module tb_mem_port_arbiter;

    typedef struct {
        logic        is_dbg;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

    logic        cpu_ack1, dbg_ack1, mem_en1, mem_we1, busy1, owner1;
    logic [31:0] cpu_rdata1, dbg_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        cpu_ack3, dbg_ack3, mem_en3, mem_we3, busy3, owner3;
    logic [31:0] cpu_rdata3, dbg_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] pipe3 [3];

    txn_t mem_q[$];
    txn_t ack_q[$];
    int   test_count = 0;
    int   fail_count = 0;
    bit   mon_en = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack1), .dbg_rdata(dbg_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1), .owner(owner1)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack3), .dbg_rdata(dbg_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3), .owner(owner3)
    );

    always #5 clk = ~clk;

    // Memory models: read data is garbage except exactly MEM_LAT cycles after a read strobe.
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 32'hA5A5_0000 | 32'(i);
            mem3[i] = 32'hA5A5_0000 | 32'(i);
        end
        mem1[8'h10] = 32'hDEAD_BEEF;
        mem3[8'h20] = 32'hCAFE_F00D;
        mem_rdata1 = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) pipe3[i] = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk);
            if (mem_en1 && mem_we1) mem1[mem_addr1[7:0]] <= mem_wdata1;
            if (mem_en3 && mem_we3) mem3[mem_addr3[7:0]] <= mem_wdata3;
            mem_rdata1 <= (mem_en1 && !mem_we1) ? mem1[mem_addr1[7:0]] : 32'hBAD0_BAD0;
            pipe3[0]   <= (mem_en3 && !mem_we3) ? mem3[mem_addr3[7:0]] : 32'hBAD0_BAD0;
            pipe3[1]   <= pipe3[0];
            pipe3[2]   <= pipe3[1];
        end
    end

    assign mem_rdata3 = pipe3[2];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic is_dbg, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (is_dbg) begin
            dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    task automatic pushTxn(input logic is_dbg, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input bit expect_ack);
        txn_t t;
        t.is_dbg = is_dbg; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        mem_q.push_back(t);
        if (expect_ack) ack_q.push_back(t);
    endtask

    // Samples one cycle of the MEM_LAT=1 instance mid-cycle, then moves to just after the next edge.
    task automatic checkCycle(input string tag, input logic en, input logic ca, input logic da, input logic bsy);
        @(negedge clk);
        checkOutput({tag, ".mem_en"},  32'(mem_en1),  32'(en));
        checkOutput({tag, ".cpu_ack"}, 32'(cpu_ack1), 32'(ca));
        checkOutput({tag, ".dbg_ack"}, 32'(dbg_ack1), 32'(da));
        checkOutput({tag, ".busy"},    32'(busy1),    32'(bsy));
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        txn_t e;
        if (mon_en && mem_en1) begin
            checkOutput("mon.mem_q_nonempty", 32'(mem_q.size() != 0), 32'd1);
            if (mem_q.size() != 0) begin
                e = mem_q.pop_front();
                checkOutput("mon.mem_we", 32'(mem_we1), 32'(e.we));
                checkOutput("mon.mem_addr", mem_addr1, e.addr);
                if (e.we) checkOutput("mon.mem_wdata", mem_wdata1, e.wdata);
            end
        end
        if (mon_en && (cpu_ack1 || dbg_ack1)) begin
            checkOutput("mon.ack_q_nonempty", 32'(ack_q.size() != 0), 32'd1);
            if (ack_q.size() != 0) begin
                e = ack_q.pop_front();
                checkOutput("mon.dbg_ack", 32'(dbg_ack1), 32'(e.is_dbg));
                checkOutput("mon.cpu_ack", 32'(cpu_ack1), 32'(!e.is_dbg));
                if (!e.we) checkOutput("mon.rdata", e.is_dbg ? dbg_rdata1 : cpu_rdata1, e.rdata);
            end
        end
    end

    initial begin
        bit d;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        resetDut();
        @(negedge clk);
        checkOutput("rst.busy", 32'(busy1), 32'd0);
        checkOutput("rst.mem_en", 32'(mem_en1), 32'd0);
        checkOutput("rst.acks", {30'd0, cpu_ack1, dbg_ack1}, 32'd0);
        checkOutput("rst.owner", 32'(owner1), 32'd1);
        checkOutput("rst.cpu_rdata", cpu_rdata1, 32'd0);
        checkOutput("rst.dbg_rdata", dbg_rdata1, 32'd0);
        checkOutput("rst.mem_addr", mem_addr1, 32'd0);
        checkOutput("rst.owner3", 32'(owner3), 32'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // CPU read at MEM_LAT=1: strobe in cycle 1, ack in cycle 3.
        pushTxn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int c = 0; c < 5; c++) begin
            if (c == 4) cpu_req = 1'b0;
            checkCycle($sformatf("cpurd.c%0d", c), c == 1, c == 3, 1'b0, c >= 1 && c <= 3);
        end
        checkOutput("cpurd.hold_rdata", cpu_rdata1, 32'hDEAD_BEEF);
        checkOutput("cpurd.dbg_rdata", dbg_rdata1, 32'd0);

        // Debug write: ack in cycle 2, read data registers untouched.
        pushTxn(1'b1, 1'b1, 32'h40, 32'h1234_5678, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) dbg_req = 1'b0;
            checkCycle($sformatf("dbgwr.c%0d", c), c == 1, 1'b0, c == 2, c == 1 || c == 2);
        end
        checkOutput("dbgwr.owner", 32'(owner1), 32'd1);
        checkOutput("dbgwr.cpu_rdata", cpu_rdata1, 32'hDEAD_BEEF);

        // Both ports request continuously: four writes, acks at cycles 2, 5, 8, 11.
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_DBG_PRIORITY_EN
            d = 1'b1;
`else
            d = (k % 2) == 1;
`endif
            pushTxn(d, 1'b1, d ? 32'hC0 : 32'h80, d ? 32'hB2B2_B2B2 : 32'hA1A1_A1A1, 32'h0, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h80, 32'hA1A1_A1A1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hC0, 32'hB2B2_B2B2);
        for (int c = 0; c < 13; c++) begin
`ifdef MEM_ARB_DBG_PRIORITY_EN
            d = 1'b1;
`else
            d = ((c / 3) % 2) == 1;
`endif
            if (c == 12) begin
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
            checkCycle($sformatf("tie.c%0d", c), c < 12 && c % 3 == 1, c < 12 && c % 3 == 2 && !d,
                       c < 12 && c % 3 == 2 && d, c < 12 && c % 3 != 0);
        end
        checkOutput("tie.owner", 32'(owner1), 32'd1);

        // Debug request held one cycle past its ack starts a second identical write.
        pushTxn(1'b1, 1'b1, 32'h50, 32'h0000_0055, 32'h0, 1'b1);
        pushTxn(1'b1, 1'b1, 32'h50, 32'h0000_0055, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h50, 32'h0000_0055);
        for (int c = 0; c < 7; c++) begin
            if (c == 4) dbg_req = 1'b0;
            checkCycle($sformatf("rereq.c%0d", c), c == 1 || c == 4, 1'b0, c == 2 || c == 5,
                       c == 1 || c == 2 || c == 4 || c == 5);
        end

        // MEM_LAT=3 instance: three WAIT cycles, ack in cycle 5, address change ignored.
        mon_en = 1'b0;
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
        for (int c = 0; c < 7; c++) begin
            if (c == 2) cpu_addr = 32'h99;
            if (c == 6) cpu_req = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("lat3.c%0d.mem_en", c), 32'(mem_en3), 32'(c == 1));
            checkOutput($sformatf("lat3.c%0d.cpu_ack", c), 32'(cpu_ack3), 32'(c == 5));
            checkOutput($sformatf("lat3.c%0d.busy", c), 32'(busy3), 32'(c >= 1 && c <= 5));
            if (c >= 1 && c <= 5) checkOutput($sformatf("lat3.c%0d.mem_addr", c), mem_addr3, 32'h20);
            if (c == 5) checkOutput("lat3.cpu_rdata", cpu_rdata3, 32'hCAFE_F00D);
            @(posedge clk);
            #1;
        end
        resetDut();
        @(negedge clk);
        checkOutput("rst2.busy", 32'(busy1), 32'd0);
        checkOutput("rst2.owner", 32'(owner1), 32'd1);
        checkOutput("rst2.cpu_rdata", cpu_rdata1, 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset during the WAIT cycle of a debug read drops it without an ack.
        pushTxn(1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
        checkCycle("midrst.c0", 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("midrst.c1", 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        dbg_req = 1'b0;
        checkCycle("midrst.c2", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        checkCycle("midrst.c3", 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("midrst.c4", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst.dbg_rdata", dbg_rdata1, 32'd0);
        checkOutput("midrst.owner", 32'(owner1), 32'd1);

        pushTxn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int c = 0; c < 5; c++) begin
            if (c == 4) cpu_req = 1'b0;
            checkCycle($sformatf("postrst.c%0d", c), c == 1, c == 3, 1'b0, c >= 1 && c <= 3);
        end

        checkOutput("end.mem_q_empty", 32'(mem_q.size()), 32'd0);
        checkOutput("end.ack_q_empty", 32'(ack_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the multicycle CPU controller and a debug/program-loader port.
- Serialises accesses, drives the memory's single port and returns data/acknowledge to the owner.
- The CPU side stalls its FSM on cpu_req & ~cpu_ack.
- Sits between the datapath's IorD address mux output and the memory.

Parameters:
- ADDR_W, 32, address width (byte address, passed through unchanged)
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous, active-low reset (rst==0 at posedge resets)
- cpu_req  input  1  CPU access request; held with addr/we/wdata stable until cpu_ack
- cpu_we  input  1  1=write, 0=read
- cpu_addr  input  ADDR_W  CPU address
- cpu_wdata  input  DATA_W  CPU write data
- cpu_ack  output  1  one-cycle completion pulse
- cpu_rdata  output  DATA_W  read data, valid while cpu_ack=1
- dbg_req  input  1  debug/loader request, same rules as cpu_req
- dbg_we  input  1  1=write
- dbg_addr  input  ADDR_W  debug address
- dbg_wdata  input  DATA_W  debug write data
- dbg_ack  output  1  one-cycle completion pulse
- dbg_rdata  output  DATA_W  read data, valid while dbg_ack=1
- mem_en  output  1  one-cycle memory strobe
- mem_we  output  1  write enable, qualified by mem_en
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- busy  output  1  1 whenever state != IDLE
- owner  output  1  0=CPU, 1=debug; current or last grant

Behaviour:
- States: IDLE, ACCESS, WAIT, ACK.
- IDLE: sample cpu_req and dbg_req.
  - Exactly one asserted: grant it.
  - Both asserted: grant the one that is not `owner` (round robin).
  - Grant latches the winner's we/addr/wdata into internal registers and sets `owner`; next state ACCESS.
  - Neither asserted: stay IDLE.
- ACCESS: mem_en=1 for exactly one cycle; mem_we/addr/wdata come from the latched registers.
  - Write: next state ACK.
  - Read: next state WAIT, with the latency counter loaded to MEM_LAT-1.
- WAIT: counter decrements each cycle. When the counter is 0, latch mem_rdata into the winner's rdata register; next state ACK.
  - For MEM_LAT=1, WAIT lasts exactly one cycle.
- ACK: winner's ack=1 for one cycle, other ack=0; next state IDLE.
- Latency, with the request first seen in IDLE at cycle 0:
  - Write: mem_en in cycle 1, ack in cycle 2.
  - Read: mem_en in cycle 1, ack in cycle MEM_LAT+2.
- req is sampled only in IDLE. A requester still asserting req in the cycle after its ack is treated as a new transaction. Changes to req/addr while not in IDLE are ignored.
- Back-to-back requests from both sides alternate CPU, DBG, CPU, … No requester waits more than one foreign transaction.
- cpu_rdata/dbg_rdata hold their last latched value between acks. Writes do not modify them.
- mem_we/mem_addr/mem_wdata are don't-care when mem_en=0; they are driven from the latched registers, not X.
- Reset (rst==0), including mid-transaction:
  - state=IDLE, mem_en=0, cpu_ack=0, dbg_ack=0.
  - owner=1, so the CPU wins the first tie.
  - Counter, rdata and latch registers cleared to 0.
  - An in-flight transaction is dropped without ack; the requester must reissue.
- Unknown/illegal state encoding: next state IDLE, all strobes 0.

Optional Feature:
- Macro MEM_ARB_DBG_PRIORITY_EN.
- Defined: on a tie in IDLE the debug port always wins. Round robin is disabled. `owner` still records the last grant. The loader may halt the CPU indefinitely.
- Undefined: round-robin tie-break as specified above.

Test Plan:
- Reset then a CPU read of addr 0x10 with MEM_LAT=1, memory returning 0xDEADBEEF → mem_en in cycle 1 with addr 0x10 and mem_we=0; cpu_ack=1 with cpu_rdata=0xDEADBEEF in cycle 3; dbg_ack stays 0.
- Debug write of addr 0x40, data 0x12345678 → mem_en=1, mem_we=1, mem_wdata=0x12345678 in cycle 1; dbg_ack in cycle 2; busy=1 in cycles 1–2.
- cpu_req and dbg_req both held continuously, 4 writes → grant order CPU, DBG, CPU, DBG; acks at cycles 2, 5, 8, 11.
  - With MEM_ARB_DBG_PRIORITY_EN defined: DBG every time, cpu_ack never asserted.
- MEM_LAT=3, CPU read → WAIT lasts 3 cycles; ack in cycle 5; cpu_addr changed to 0x99 during WAIT has no effect on mem_addr.
- rst=0 asserted in a WAIT cycle of a debug read → next cycle state IDLE, no dbg_ack, mem_en=0. A CPU request issued after rst=1 completes normally.
- dbg_req held for one extra cycle after dbg_ack → a second identical transaction runs (mem_en pulses again).
